// File: rtl/tcu_drl_acc_norm_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// tcu_drl_acc_norm_pkg : shared TCU format IDs, widths, stage payload
// Rev 1.0
// ------------------------------------------------------------------
package tcu_drl_acc_norm_pkg;

  localparam int N          = 2;
  localparam int TCK        = 2 * N;
  localparam int W          = 25;
  localparam int ACC_W      = W + $clog2(TCK + 1) + 1;
  localparam int MAG_W      = ACC_W - 1;
  localparam int LZC_W      = $clog2(MAG_W + 1);
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  localparam logic [3:0] TCU_FP32_ID = 4'd0;
  localparam logic [3:0] TCU_FP16_ID = 4'd1;
  localparam logic [3:0] TCU_BF16_ID = 4'd2;
  localparam logic [3:0] TCU_I32_ID  = 4'd8;
  localparam logic [3:0] TCU_I8_ID   = 4'd9;
  localparam logic [3:0] TCU_U8_ID   = 4'd10;
  localparam logic [3:0] TCU_I4_ID   = 4'd11;
  localparam logic [3:0] TCU_U4_ID   = 4'd12;

  typedef struct packed {
    logic        valid;
    logic [31:0] val;
  } exc_t;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic             sgn;
    logic             zero;
    logic [LZC_W-1:0] lzc;
    logic [9:0]       max_exp;
    logic [3:0]       fmt;
    exc_t             exc;
  } stage_t;

  function automatic logic is_unsigned_int(input logic [3:0] fmt);
    return (fmt == TCU_U8_ID) || (fmt == TCU_U4_ID);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tcu_drl_acc_norm_if.sv
`default_nettype none
// ------------------------------------------------------------------
// tcu_drl_acc_norm_if : term-beat input / result output handshake
// Rev 1.0
// ------------------------------------------------------------------
interface tcu_drl_acc_norm_if;
  import tcu_drl_acc_norm_pkg::*;

  logic                   valid_in;
  logic                   ready_in;
  logic [3:0]             fmt_s;
  logic [(TCK+1)*W-1:0]   terms;
  logic [9:0]             max_exp;
  logic                   exc_valid;
  logic [31:0]            exc_val;
  logic                   valid_out;
  logic                   ready_out;
  logic [31:0]            result;
  logic                   overflow;

  modport slave (
    input  valid_in, fmt_s, terms, max_exp, exc_valid, exc_val, ready_out,
    output ready_in, valid_out, result, overflow
  );

  modport master (
    output valid_in, fmt_s, terms, max_exp, exc_valid, exc_val, ready_out,
    input  ready_in, valid_out, result, overflow
  );
endinterface
`default_nettype wire

// File: rtl/tcu_drl_acc_norm_lzc.sv
`default_nettype none
// ------------------------------------------------------------------
// tcu_drl_lzc : leading-zero count; all-zero input returns WIDTH
// Rev 1.0
// ------------------------------------------------------------------
module tcu_drl_lzc #(
  parameter int WIDTH = 28,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [CNT_W-1:0] o_count
);
  // Later (higher) set bits overwrite, so the most significant one wins.
  always_comb begin
    o_count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (i_data[i]) o_count = CNT_W'(WIDTH - 1 - i);
    end
  end
endmodule
`default_nettype wire

// File: rtl/tcu_drl_acc_norm.sv
`default_nettype none
// ------------------------------------------------------------------
// tcu_drl_acc_norm : 3-stage sum / LZC / normalize+RNE to FP32 or int32
// Rev 1.0
// ------------------------------------------------------------------
module tcu_drl_acc_norm
  import tcu_drl_acc_norm_pkg::*;
(
  input wire logic          clk,
  input wire logic          reset,
  tcu_drl_acc_norm_if.slave bus
);

  logic             w_en;
  logic [W-1:0]     w_term  [TCK+1];
  logic [ACC_W-1:0] w_ext   [TCK+1];
  logic [ACC_W-1:0] w_cs_s, w_cs_c, w_cs_t, w_sum;
  stage_t           w_s1_next, w_s2_next, r_s1, r_s2;
  logic             r_s1_valid, r_s2_valid;
  logic [MAG_W-1:0] w_mag, w_norm;
  logic [LZC_W-1:0] w_lzc;
  logic [FP32_MAN_W:0]   w_man;
  logic [FP32_MAN_W+1:0] w_man_rnd;
  logic [FP32_MAN_W-1:0] w_frac;
  logic             w_g, w_r, w_s, w_inc, w_is_int;
  logic signed [11:0] w_exp, w_exp_rnd;
  logic [31:0]      w_res;
  logic             w_ovf;
  logic             r_valid_out, r_overflow;
  logic [31:0]      r_result;

  assign w_en         = !r_valid_out || bus.ready_out;
  assign bus.ready_in = w_en;
  assign bus.valid_out = r_valid_out;
  assign bus.result    = r_result;
  assign bus.overflow  = r_overflow;

  // Stage 1: bring every term to two's complement at ACC_W bits.
  always_comb begin
    for (int i = 0; i <= TCK; i++) begin
      w_term[i] = bus.terms[i*W +: W];
      if (bus.fmt_s >= TCU_I32_ID) begin
        if (is_unsigned_int(bus.fmt_s)) w_ext[i] = {{(ACC_W-W){1'b0}}, w_term[i]};
        else                            w_ext[i] = {{(ACC_W-W){w_term[i][W-1]}}, w_term[i]};
      end else begin
        w_ext[i] = {{(ACC_W-W+1){1'b0}}, w_term[i][W-2:0]};
        if (w_term[i][W-1]) w_ext[i] = ~w_ext[i] + ACC_W'(1);
      end
    end
  end

  // Carry-save accumulation of all terms, one carry-propagate add at the end.
  always_comb begin
    w_cs_s = '0;
    w_cs_c = '0;
    w_cs_t = '0;
    for (int i = 0; i <= TCK; i++) begin
      w_cs_t = w_cs_s ^ w_cs_c ^ w_ext[i];
      w_cs_c = ((w_cs_s & w_cs_c) | (w_cs_s & w_ext[i]) | (w_cs_c & w_ext[i])) << 1;
      w_cs_s = w_cs_t;
    end
    w_sum = w_cs_s + w_cs_c;
  end

  always_comb begin
    w_s1_next           = '0;
    w_s1_next.sum       = w_sum;
    w_s1_next.max_exp   = bus.max_exp;
    w_s1_next.fmt       = bus.fmt_s;
    w_s1_next.exc.valid = bus.exc_valid;
    w_s1_next.exc.val   = bus.exc_val;
  end

  // Stage 2: magnitude and leading-zero count. Integer beats keep the raw sum.
  assign w_mag = r_s1.sum[ACC_W-1] ? MAG_W'(~r_s1.sum + ACC_W'(1)) : r_s1.sum[MAG_W-1:0];

  tcu_drl_lzc #(.WIDTH(MAG_W), .CNT_W(LZC_W)) u_lzc (
    .i_data  (w_mag),
    .o_count (w_lzc)
  );

  always_comb begin
    w_s2_next      = r_s1;
    w_s2_next.sgn  = r_s1.sum[ACC_W-1];
    w_s2_next.zero = (w_mag == '0);
    w_s2_next.lzc  = w_lzc;
    if (r_s1.fmt < TCU_I32_ID) w_s2_next.sum = {1'b0, w_mag};
  end

  // Stage 3: normalize, round to nearest even, pack.
  always_comb begin
    w_is_int  = (r_s2.fmt >= TCU_I32_ID);
    w_norm    = r_s2.sum[MAG_W-1:0] << r_s2.lzc;
    w_man     = w_norm[MAG_W-1 -: FP32_MAN_W+1];
    w_g       = w_norm[MAG_W-FP32_MAN_W-2];
    w_r       = w_norm[MAG_W-FP32_MAN_W-3];
    w_s       = |w_norm[MAG_W-FP32_MAN_W-4:0];
    w_inc     = w_g & (w_r | w_s | w_man[0]);
    w_man_rnd = {1'b0, w_man} + {{(FP32_MAN_W+1){1'b0}}, w_inc};
    w_frac    = w_man_rnd[FP32_MAN_W+1] ? w_man_rnd[FP32_MAN_W:1] : w_man_rnd[FP32_MAN_W-1:0];
    // Leading one sits at ACC_W-2-lzc; magnitude bit W-2 carries max_exp.
    w_exp     = {2'b00, r_s2.max_exp} + 12'(ACC_W - W) - 12'(r_s2.lzc);
    w_exp_rnd = w_exp + 12'(w_man_rnd[FP32_MAN_W+1]);
    w_ovf     = 1'b0;
    w_res     = {r_s2.sgn, w_exp_rnd[FP32_EXP_W-1:0], w_frac};
    if (r_s2.exc.valid) begin
      w_res = r_s2.exc.val;
    end else if (w_is_int) begin
      w_res = {{(32-ACC_W){r_s2.sum[ACC_W-1]}}, r_s2.sum};
    end else if (r_s2.zero) begin
      w_res = 32'd0;
    end else if (w_exp_rnd >= 12'sd255) begin
      w_res = {r_s2.sgn, 8'hFF, 23'd0};
      w_ovf = 1'b1;
    end else if (w_exp_rnd <= 12'sd0) begin
      w_res = {r_s2.sgn, 31'd0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_valid_out <= 1'b0;
      r_result    <= 32'd0;
      r_overflow  <= 1'b0;
    end else if (w_en) begin
      r_s1_valid  <= bus.valid_in;
      r_s1        <= w_s1_next;
      r_s2_valid  <= r_s1_valid;
      r_s2        <= w_s2_next;
      r_valid_out <= r_s2_valid;
      r_result    <= w_res;
      r_overflow  <= w_ovf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tcu_drl_acc_norm.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_tcu_drl_acc_norm : directed-vector bench for tcu_drl_acc_norm
// Rev 1.0
// ------------------------------------------------------------------
module tb_tcu_drl_acc_norm;
  import tcu_drl_acc_norm_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  tcu_drl_acc_norm_if bus_if ();

  tcu_drl_acc_norm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [(TCK+1)*W-1:0] pk(input logic [W-1:0] t0, t1, t2, t3, t4);
    return {t4, t3, t2, t1, t0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] fmt, input logic [(TCK+1)*W-1:0] t,
                       input logic [9:0] mexp, input logic exv, input logic [31:0] exval);
    bus_if.fmt_s     = fmt;
    bus_if.terms     = t;
    bus_if.max_exp   = mexp;
    bus_if.exc_valid = exv;
    bus_if.exc_val   = exval;
  endtask

  // One isolated beat: checks acceptance, the 3-cycle latency, and the result.
  task automatic run_one(input string tag, input logic [3:0] fmt, input logic [(TCK+1)*W-1:0] t,
                         input logic [9:0] mexp, input logic exv, input logic [31:0] exval,
                         input logic [31:0] exp_res, input logic exp_ovf);
    @(negedge clk);
    drive(fmt, t, mexp, exv, exval);
    bus_if.valid_in  = 1'b1;
    bus_if.ready_out = 1'b1;
    chk({tag, "_rdy"}, {31'd0, bus_if.ready_in}, 32'd1);
    @(negedge clk);
    bus_if.valid_in = 1'b0;
    chk({tag, "_lat1"}, {31'd0, bus_if.valid_out}, 32'd0);
    @(negedge clk);
    chk({tag, "_lat2"}, {31'd0, bus_if.valid_out}, 32'd0);
    @(negedge clk);
    chk({tag, "_vld"}, {31'd0, bus_if.valid_out}, 32'd1);
    chk({tag, "_res"}, bus_if.result, exp_res);
    chk({tag, "_ovf"}, {31'd0, bus_if.overflow}, {31'd0, exp_ovf});
  endtask

  initial begin
    reset = 1'b1;
    bus_if.valid_in  = 1'b0;
    bus_if.ready_out = 1'b1;
    drive(TCU_FP32_ID, '0, 10'd0, 1'b0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_ready_in", {31'd0, bus_if.ready_in}, 32'd1);
    chk("rst_valid_out", {31'd0, bus_if.valid_out}, 32'd0);
    chk("rst_result", bus_if.result, 32'd0);
    chk("rst_overflow", {31'd0, bus_if.overflow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_in", {31'd0, bus_if.ready_in}, 32'd1);

    run_one("fp32_one",   TCU_FP32_ID, pk(25'h0800000, 0, 0, 0, 0), 10'd127, 1'b0, 0, 32'h3F800000, 1'b0);
    run_one("fp16_cancel", TCU_FP16_ID, pk(25'h0800000, 25'h1800000, 0, 0, 0), 10'd127, 1'b0, 0, 32'h00000000, 1'b0);
    run_one("fp32_five",  TCU_FP32_ID, {5{25'h0800000}}, 10'd127, 1'b0, 0, 32'h40A00000, 1'b0);
    run_one("rne_tie_even", TCU_FP32_ID, pk(25'h0800000, 25'h0800001, 0, 0, 0), 10'd127, 1'b0, 0, 32'h40000000, 1'b0);
    run_one("rne_tie_odd", TCU_FP32_ID, pk(25'h0800000, 25'h0800003, 0, 0, 0), 10'd127, 1'b0, 0, 32'h40000002, 1'b0);
    run_one("rnd_carry",  TCU_FP32_ID, pk(25'h0FFFFFF, 25'h0FFFFFF, 25'h0000001, 0, 0), 10'd127, 1'b0, 0, 32'h40800000, 1'b0);
    run_one("fp32_neg",   TCU_FP32_ID, pk(25'h1800000, 0, 0, 0, 0), 10'd127, 1'b0, 0, 32'hBF800000, 1'b0);
    run_one("fp16_negsum", TCU_FP16_ID, pk(25'h0800000, 25'h1C00000, 0, 0, 0), 10'd127, 1'b0, 0, 32'hBF000000, 1'b0);
    run_one("flush",      TCU_FP32_ID, pk(25'h1400000, 0, 0, 0, 0), 10'd1, 1'b0, 0, 32'h80000000, 1'b0);
    run_one("min_normal", TCU_FP32_ID, pk(25'h0400000, 0, 0, 0, 0), 10'd2, 1'b0, 0, 32'h00800000, 1'b0);
    run_one("max_finite", TCU_FP32_ID, pk(25'h0800000, 0, 0, 0, 0), 10'd254, 1'b0, 0, 32'h7F000000, 1'b0);
    run_one("overflow",   TCU_FP32_ID, pk(25'h0800000, 25'h0800000, 0, 0, 0), 10'd254, 1'b0, 0, 32'h7F800000, 1'b1);
    run_one("exc",        TCU_FP32_ID, pk(25'h0800000, 25'h0800000, 0, 0, 0), 10'd254, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b0);
    run_one("i8_sum",     TCU_I8_ID, pk(25'h1FFFFFF, 25'd3, 0, 0, 0), 10'd0, 1'b0, 0, 32'h00000002, 1'b0);
    run_one("u4_sum",     TCU_U4_ID, {5{25'd7}}, 10'd0, 1'b0, 0, 32'h00000023, 1'b0);
    run_one("i8_neg",     TCU_I8_ID, pk(25'h1FFFFFB, 0, 0, 0, 0), 10'd0, 1'b0, 0, 32'hFFFFFFFB, 1'b0);

    // Back-to-back beats into a stalled output.
    @(negedge clk);
    bus_if.ready_out = 1'b0;
    bus_if.valid_in  = 1'b1;
    drive(TCU_FP32_ID, pk(25'h0800000, 0, 0, 0, 0), 10'd127, 1'b0, 0);
    @(negedge clk);
    drive(TCU_I8_ID, pk(25'h1FFFFFF, 25'd3, 0, 0, 0), 10'd0, 1'b0, 0);
    @(negedge clk);
    drive(TCU_U4_ID, {5{25'd7}}, 10'd0, 1'b0, 0);
    @(negedge clk);
    drive(TCU_FP32_ID, pk(25'h1800000, 0, 0, 0, 0), 10'd127, 1'b0, 0);
    chk("stall_vld", {31'd0, bus_if.valid_out}, 32'd1);
    chk("stall_res", bus_if.result, 32'h3F800000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_hold_rdy", {31'd0, bus_if.ready_in}, 32'd0);
      chk("stall_hold_res", bus_if.result, 32'h3F800000);
      chk("stall_hold_vld", {31'd0, bus_if.valid_out}, 32'd1);
    end
    bus_if.ready_out = 1'b1;
    @(negedge clk);
    bus_if.valid_in = 1'b0;
    chk("drain_b_vld", {31'd0, bus_if.valid_out}, 32'd1);
    chk("drain_b_res", bus_if.result, 32'h00000002);
    @(negedge clk);
    chk("drain_c_vld", {31'd0, bus_if.valid_out}, 32'd1);
    chk("drain_c_res", bus_if.result, 32'h00000023);
    @(negedge clk);
    chk("drain_d_vld", {31'd0, bus_if.valid_out}, 32'd1);
    chk("drain_d_res", bus_if.result, 32'hBF800000);
    @(negedge clk);
    chk("drain_empty", {31'd0, bus_if.valid_out}, 32'd0);

    // Reset while the pipeline is full.
    @(negedge clk);
    bus_if.valid_in = 1'b1;
    drive(TCU_FP32_ID, pk(25'h0800000, 25'h0800000, 0, 0, 0), 10'd254, 1'b0, 0);
    @(negedge clk);
    drive(TCU_FP32_ID, pk(25'h0800000, 0, 0, 0, 0), 10'd127, 1'b0, 0);
    @(negedge clk);
    drive(TCU_I8_ID, pk(25'h1FFFFFF, 25'd3, 0, 0, 0), 10'd0, 1'b0, 0);
    @(negedge clk);
    bus_if.valid_in = 1'b0;
    chk("prerst_vld", {31'd0, bus_if.valid_out}, 32'd1);
    chk("prerst_res", bus_if.result, 32'h7F800000);
    chk("prerst_ovf", {31'd0, bus_if.overflow}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_vld", {31'd0, bus_if.valid_out}, 32'd0);
    chk("async_rst_res", bus_if.result, 32'd0);
    chk("async_rst_ovf", {31'd0, bus_if.overflow}, 32'd0);
    chk("async_rst_rdy", {31'd0, bus_if.ready_in}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale", {31'd0, bus_if.valid_out}, 32'd0);
    end
    run_one("after_rst", TCU_FP32_ID, {5{25'h0800000}}, 10'd127, 1'b0, 0, 32'h40A00000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
